// File: rtl/qmac_accum.sv
// qmac_accum -- saturating Q(I.F) frame accumulator.
//
// Sits directly behind the saturating Q(I.F) multiplier in the DEM-DAC
// filter datapath. Adds N consecutive signed products with saturation at
// every step and emits one saturated dot-product result per frame.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   clear_i       synchronous frame abort (zeroes accumulator and count)
//   prod_i        signed Q(I.F) product from the multiplier
//   prod_valid_i  prod_i valid
//   prod_ready_o  stage accepts prod_i this cycle
//   acc_o         signed Q(I.F) saturated frame sum
//   sat_o         some add in the reported frame saturated
//   acc_valid_o   acc_o / sat_o valid
//   acc_ready_i   downstream accepts the result
module qmac_accum #(
  parameter int I = 16,
  parameter int F = 16,
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic [I+F-1:0] prod_i,
  input  logic           prod_valid_i,
  output logic           prod_ready_o,
  output logic [I+F-1:0] acc_o,
  output logic           sat_o,
  output logic           acc_valid_o,
  input  logic           acc_ready_i
);

  localparam int W  = I + F;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frameSat_q, frameSat_d;
  logic [W-1:0]    accOut_q, accOut_d;
  logic            satOut_q, satOut_d;

  logic [W:0]      sumWide;
  logic [W-1:0]    sumSat;
  logic            addSat;
  logic            accept;
  logic            lastBeat;

  // Saturating add: one guard bit catches overflow; when the two top bits
  // of the widened sum disagree the result left the W-bit range, and the
  // guard bit tells us which rail to clamp to.
  always_comb begin
    sumWide = {acc_q[W-1], acc_q} + {prod_i[W-1], prod_i};
    addSat  = sumWide[W] ^ sumWide[W-1];
    sumSat  = sumWide[W-1:0];
    if (addSat) begin
      sumSat = sumWide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Ready depends only on state, clear and reset, never on prod_valid_i or
  // acc_ready_i, so downstream backpressure reaches the multiplier one
  // cycle late rather than through a combinational chain.
  assign prod_ready_o = (state_q == ACCUM) && !clear_i && !rst_i;
  assign accept       = prod_valid_i && prod_ready_o;
  assign lastBeat     = (cnt_q == CW'(N - 1));

  // Outputs are forced to zero while reset is asserted so the result
  // channel goes quiet immediately, not only after the reset edge.
  assign acc_valid_o = (state_q == DUMP) && !rst_i;
  assign acc_o       = rst_i ? '0 : accOut_q;
  assign sat_o       = rst_i ? 1'b0 : satOut_q;

  // Next-state logic. In ACCUM the accumulator collects products; the last
  // beat of a frame moves the saturated sum into the output register and
  // restarts the accumulator so the next frame starts clean. In DUMP the
  // held result waits for the handshake and clear_i has no effect.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    frameSat_d = frameSat_q;
    accOut_d   = accOut_q;
    satOut_d   = satOut_q;

    case (state_q)
      ACCUM: begin
        if (clear_i) begin
          acc_d      = '0;
          cnt_d      = '0;
          frameSat_d = 1'b0;
        end else if (accept) begin
          if (lastBeat) begin
            accOut_d   = sumSat;
            satOut_d   = frameSat_q | addSat;
            acc_d      = '0;
            cnt_d      = '0;
            frameSat_d = 1'b0;
            state_d    = DUMP;
          end else begin
            acc_d      = sumSat;
            cnt_d      = cnt_q + CW'(1);
            frameSat_d = frameSat_q | addSat;
          end
        end
      end
      DUMP: begin
        if (acc_ready_i) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      frameSat_q <= 1'b0;
      accOut_q   <= '0;
      satOut_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      frameSat_q <= frameSat_d;
      accOut_q   <= accOut_d;
      satOut_q   <= satOut_d;
    end
  end

endmodule

// File: tb/tb_qmac_accum.sv
// tb_qmac_accum -- directed self-checking bench for qmac_accum.
//
// Three instances share clock, reset, clear, product data and acc_ready:
//   index 0 -> N=4, index 1 -> N=2, index 2 -> N=1.
// Each instance has its own prod_valid so only the addressed one accepts.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_qmac_accum;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] prodI;
  logic        accReady;
  logic        prodValidI [3];
  logic        prodReadyO [3];
  logic [31:0] accO       [3];
  logic        satO       [3];
  logic        accValidO  [3];

  int checks = 0;
  int errors = 0;

  qmac_accum #(.I(16), .F(16), .N(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .prod_i(prodI), .prod_valid_i(prodValidI[0]), .prod_ready_o(prodReadyO[0]),
    .acc_o(accO[0]), .sat_o(satO[0]), .acc_valid_o(accValidO[0]),
    .acc_ready_i(accReady)
  );

  qmac_accum #(.I(16), .F(16), .N(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .prod_i(prodI), .prod_valid_i(prodValidI[1]), .prod_ready_o(prodReadyO[1]),
    .acc_o(accO[1]), .sat_o(satO[1]), .acc_valid_o(accValidO[1]),
    .acc_ready_i(accReady)
  );

  qmac_accum #(.I(16), .F(16), .N(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .prod_i(prodI), .prod_valid_i(prodValidI[2]), .prod_ready_o(prodReadyO[2]),
    .acc_o(accO[2]), .sat_o(satO[2]), .acc_valid_o(accValidO[2]),
    .acc_ready_i(accReady)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offers one product to instance sel starting at a falling edge and
  // returns at the falling edge right after the accepting rising edge.
  task automatic applyStimulus(input int sel, input logic [31:0] value);
    bit done;
    done = 1'b0;
    prodI = value;
    prodValidI[sel] = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (prodReadyO[sel]) done = 1'b1;
      @(negedge clk);
    end
    prodValidI[sel] = 1'b0;
    if (!done) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  // Sends a whole frame; checks the result is not yet valid before the
  // last beat, then result, saturation flag and latency-1 valid after it.
  task automatic sendFrame(input int sel, input int n, input logic [31:0] vals [4],
                           input logic [31:0] expAcc, input logic expSat,
                           input string tag);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) checkOutput({tag, " valid before last"}, {31'd0, accValidO[sel]}, 32'd0);
      applyStimulus(sel, vals[i]);
    end
    checkOutput({tag, " valid"}, {31'd0, accValidO[sel]}, 32'd1);
    checkOutput({tag, " acc"}, accO[sel], expAcc);
    checkOutput({tag, " sat"}, {31'd0, satO[sel]}, {31'd0, expSat});
  endtask

  // One-cycle acc_ready pulse, then the result must be gone and input open.
  task automatic drainResult(input int sel, input string tag);
    accReady = 1'b1;
    @(negedge clk);
    accReady = 1'b0;
    #1;
    checkOutput({tag, " drained valid"}, {31'd0, accValidO[sel]}, 32'd0);
    checkOutput({tag, " drained ready"}, {31'd0, prodReadyO[sel]}, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] vec [4];

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    accReady = 1'b0;
    prodI = '0;
    for (int i = 0; i < 3; i++) prodValidI[i] = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset ready", {31'd0, prodReadyO[0]}, 32'd0);
    checkOutput("reset valid", {31'd0, accValidO[0]}, 32'd0);
    checkOutput("reset acc", accO[0], 32'd0);
    checkOutput("reset sat", {31'd0, satO[0]}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset ready", {31'd0, prodReadyO[0]}, 32'd1);
    @(negedge clk);

    // 1.0 + 2.0 - 0.5 + 0.25 = 2.75
    vec = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0000_4000};
    sendFrame(0, 4, vec, 32'h0002_C000, 1'b0, "t1");
    drainResult(0, "t1");

    // Positive clamp, then a clean frame must not inherit the flag.
    vec = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
    sendFrame(0, 4, vec, 32'h7FFF_FFFF, 1'b1, "t2a");
    drainResult(0, "t2a");
    vec = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    sendFrame(0, 4, vec, 32'h0004_0000, 1'b0, "t2b");
    drainResult(0, "t2b");

    // Negative clamp on N=2.
    vec = '{32'h8000_0000, 32'hFFFF_0000, 32'h0, 32'h0};
    sendFrame(1, 2, vec, 32'h8000_0000, 1'b1, "t3");
    drainResult(1, "t3");

    // Backpressure: result held for 5 cycles, clear_i ignored meanwhile.
    vec = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    sendFrame(0, 4, vec, 32'h0004_0000, 1'b0, "t4");
    for (int c = 0; c < 5; c++) begin
      clear = (c == 2);
      @(negedge clk);
      clear = 1'b0;
      #1;
      checkOutput("t4 hold valid", {31'd0, accValidO[0]}, 32'd1);
      checkOutput("t4 hold acc", accO[0], 32'h0004_0000);
      checkOutput("t4 hold ready", {31'd0, prodReadyO[0]}, 32'd0);
    end
    accReady = 1'b1;
    #1;
    checkOutput("t4 ready in handshake cycle", {31'd0, prodReadyO[0]}, 32'd0);
    @(negedge clk);
    accReady = 1'b0;
    #1;
    checkOutput("t4 ready after handshake", {31'd0, prodReadyO[0]}, 32'd1);
    checkOutput("t4 valid after handshake", {31'd0, accValidO[0]}, 32'd0);
    @(negedge clk);

    // Mid-frame clear discards the partial sum.
    applyStimulus(0, 32'h0005_0000);
    applyStimulus(0, 32'h0007_0000);
    clear = 1'b1;
    #1;
    checkOutput("t5 ready during clear", {31'd0, prodReadyO[0]}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    sendFrame(0, 4, vec, 32'h0004_0000, 1'b0, "t5 clear");
    drainResult(0, "t5 clear");

    // Mid-frame reset behaves the same and silences all outputs.
    applyStimulus(0, 32'h0005_0000);
    applyStimulus(0, 32'h0007_0000);
    rst = 1'b1;
    #1;
    checkOutput("t5 rst ready", {31'd0, prodReadyO[0]}, 32'd0);
    checkOutput("t5 rst acc", accO[0], 32'd0);
    @(negedge clk);
    checkOutput("t5 rst valid", {31'd0, accValidO[0]}, 32'd0);
    checkOutput("t5 rst sat", {31'd0, satO[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    sendFrame(0, 4, vec, 32'h0004_0000, 1'b0, "t5 rst");
    drainResult(0, "t5 rst");

    // N=1 streaming with the result channel always ready.
    accReady = 1'b1;
    applyStimulus(2, 32'h0003_0000);
    checkOutput("t6 first valid", {31'd0, accValidO[2]}, 32'd1);
    checkOutput("t6 first acc", accO[2], 32'h0003_0000);
    checkOutput("t6 first sat", {31'd0, satO[2]}, 32'd0);
    applyStimulus(2, 32'hFFFD_0000);
    checkOutput("t6 second valid", {31'd0, accValidO[2]}, 32'd1);
    checkOutput("t6 second acc", accO[2], 32'hFFFD_0000);
    checkOutput("t6 second sat", {31'd0, satO[2]}, 32'd0);
    @(negedge clk);
    accReady = 1'b0;
    checkOutput("t6 drained valid", {31'd0, accValidO[2]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
